spi_adc_reader: RTL and testbench
=================================

SPI_ADC_READER -- requirements
Module: spi_adc_reader

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, meaning system clocks per SCLK half-period (legal range 2..255).
REQ-002 The block SHALL have parameter CMD_BYTE, default 8'h01, meaning the read command byte sent before each conversion read.
REQ-003 The block SHALL have port clock_i, input, width 1, meaning the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_i, input, width 1, meaning asynchronous, active-high reset.
REQ-005 The block SHALL have port start_i, input, width 1, meaning a request for one conversion read, sampled only in IDLE.
REQ-006 The block SHALL have port drdy_n_i, input, width 1, meaning ADC data-ready, active-low, already synchronized to clock_i.
REQ-007 The block SHALL have port delay_done_i, input, width 1, meaning the done flag from the external spi_delay_timer.
REQ-008 The block SHALL have port delay_en_o, output, width 1, meaning the enable to the external spi_delay_timer.
REQ-009 The block SHALL have port miso_i, input, width 1, meaning ADC serial data out.
REQ-010 The block SHALL have ports sclk_o, mosi_o and cs_n_o, each output, width 1, meaning SPI clock, SPI data to ADC and chip select (active-low).
REQ-011 The block SHALL have port data_o, output, width 24, meaning the last conversion result, MSB first as received.
REQ-012 The block SHALL have ports data_valid_o and busy_o, each output, width 1, meaning a one-cycle result strobe and a flag that is high in any state other than IDLE.

Function
REQ-013 The FSM SHALL use states IDLE, WAIT_DRDY, SEND_CMD, DELAY, READ and DONE.
REQ-014 IDLE -> WAIT_DRDY SHALL occur on start_i=1; start_i in any other state SHALL be ignored, with no queuing.
REQ-015 WAIT_DRDY -> SEND_CMD SHALL occur on the first cycle drdy_n_i=0; while drdy_n_i=1 the block SHALL wait indefinitely with cs_n_o=1.
REQ-016 cs_n_o SHALL be 0 from the first cycle of SEND_CMD through the last cycle of READ; otherwise it SHALL be 1.
REQ-017 The SCLK generator SHALL run in SEND_CMD and READ: a half-period counter 0..CLK_DIV-1 SHALL toggle sclk_o at the terminal count, giving a period of 2*CLK_DIV clocks; sclk_o idles at 0 (CPOL=0, CPHA=1).
REQ-018 In SEND_CMD, mosi_o SHALL present CMD_BYTE MSB first, updating on each SCLK rising edge; exactly 8 SCLK pulses SHALL be issued.
REQ-019 After the 8th SCLK falling edge the block SHALL enter DELAY with sclk_o=0 and mosi_o=0.
REQ-020 delay_en_o SHALL be 1 in every DELAY cycle and 0 in all other states; DELAY -> READ SHALL occur the cycle after delay_done_i=1 is sampled, so the timer is re-armed for the next transaction.
REQ-021 In READ, miso_i SHALL be sampled into a 24-bit shift register on each SCLK falling edge, MSB first; exactly 24 SCLK pulses SHALL be issued.
REQ-022 After the 24th falling edge the block SHALL enter DONE: data_o loads the shift register, data_valid_o=1 for exactly that one cycle, and the next state is IDLE.
REQ-023 data_o SHALL hold its value until the next DONE.
REQ-024 Minimum start-to-valid latency SHALL be 2 (IDLE/WAIT_DRDY) + 16*CLK_DIV + DELAY cycles + 48*CLK_DIV + 1 clocks, with drdy_n_i already low.

Reset
REQ-025 When reset_i=1, the block SHALL immediately and asynchronously set the state to IDLE, with cs_n_o=1, sclk_o=0, mosi_o=0, delay_en_o=0, data_valid_o=0, busy_o=0, data_o=0 and all counters=0.
REQ-026 A reset asserted mid-transaction SHALL abort the transaction with no data_valid_o pulse; the first start_i after reset release SHALL run a complete, correct transaction.

Verification
REQ-027 CLK_DIV=2, timer MAX_COUNT=50, ADC model returns 24'hA5C3F0, drdy_n_i=0, start_i pulsed -> MOSI bits captured = 8'h01, data_o=24'hA5C3F0, data_valid_o high for exactly 1 cycle.
REQ-028 Same run -> exactly 8 then 24 sclk_o rising edges; the gap between them is at least 50 clocks with sclk_o=0, cs_n_o=0 and delay_en_o=1.
REQ-029 drdy_n_i held at 1 for 100 cycles after start_i -> cs_n_o=1, sclk_o=0 and busy_o=1 throughout; drdy_n_i falls -> cs_n_o=0 on the next cycle.
REQ-030 start_i pulsed during READ -> no second transaction; busy_o=0 one cycle after DONE.
REQ-031 reset_i asserted after the 10th READ SCLK pulse -> cs_n_o=1, sclk_o=0 and delay_en_o=0 without waiting for a clock edge, and no valid pulse; a new start_i returns the ADC model word 24'h123456 correctly.
REQ-032 Back-to-back transactions returning 24'hFFFFFF then 24'h000000 -> both values appear on data_o in order, and delay_en_o drops between the two transactions.

Source files
------------

// File: rtl/spi_adc_reader.sv
// SPI master (CPOL=0, CPHA=1) that reads one 24-bit ADC conversion: waits for DRDY,
// sends a read command, waits on an external delay timer, then shifts in the result.
module spi_adc_reader #(
   parameter int unsigned CLK_DIV  = 4,
   parameter logic [7:0]  CMD_BYTE = 8'h01
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic        drdy_n_i,
   input  logic        delay_done_i,
   output logic        delay_en_o,
   input  logic        miso_i,
   output logic        sclk_o,
   output logic        mosi_o,
   output logic        cs_n_o,
   output logic [23:0] data_o,
   output logic        data_valid_o,
   output logic        busy_o
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_DRDY,
      SEND_CMD,
      DELAY,
      READ,
      DONE
   } state_e;

   localparam logic [7:0] DIV_LAST       = 8'(CLK_DIV - 1);
   // Edge counters count SCLK half-periods: 8 pulses = 16, 24 pulses = 48.
   localparam logic [5:0] CMD_LAST_EDGE  = 6'd15;
   localparam logic [5:0] READ_LAST_EDGE = 6'd47;

   state_e      state_q, state_d;
   logic [7:0]  div_q, div_d;
   logic [5:0]  edge_q, edge_d;
   logic        sclk_q, sclk_d;
   logic        mosi_q, mosi_d;
   logic [23:0] shift_q, shift_d;
   logic [23:0] data_q, data_d;
   logic        half_done;

   assign half_done = (div_q == DIV_LAST);

   always_comb begin
      // NOTE: every next-state signal is defaulted to its register first, so no path
      // through the case statement can leave one unassigned and infer a latch.
      state_d = state_q;
      div_d   = div_q;
      edge_d  = edge_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      shift_d = shift_q;
      data_d  = data_q;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = WAIT_DRDY;
            end
         end

         WAIT_DRDY: begin
            if (!drdy_n_i) begin
               state_d = SEND_CMD;
               div_d   = '0;
               edge_d  = '0;
               sclk_d  = 1'b0;
               mosi_d  = 1'b0;
            end
         end

         SEND_CMD: begin
            if (half_done) begin
               div_d  = '0;
               sclk_d = ~sclk_q;
               // CPHA=1: the command bit changes on the SCLK rising edge.
               if (!sclk_q) begin
                  mosi_d = CMD_BYTE[3'd7 - edge_q[3:1]];
               end
               if (edge_q == CMD_LAST_EDGE) begin
                  state_d = DELAY;
                  edge_d  = '0;
                  mosi_d  = 1'b0;
               end else begin
                  edge_d = edge_q + 6'd1;
               end
            end else begin
               div_d = div_q + 8'd1;
            end
         end

         DELAY: begin
            if (delay_done_i) begin
               state_d = READ;
               div_d   = '0;
               edge_d  = '0;
               sclk_d  = 1'b0;
            end
         end

         READ: begin
            if (half_done) begin
               div_d  = '0;
               sclk_d = ~sclk_q;
               if (sclk_q) begin
                  shift_d = {shift_q[22:0], miso_i};
               end
               if (edge_q == READ_LAST_EDGE) begin
                  state_d = DONE;
                  edge_d  = '0;
               end else begin
                  edge_d = edge_q + 6'd1;
               end
            end else begin
               div_d = div_q + 8'd1;
            end
         end

         DONE: begin
            data_d  = shift_q;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         div_q   <= '0;
         edge_q  <= '0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         shift_q <= '0;
         data_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the values from
         // before this edge, independent of statement order.
         state_q <= state_d;
         div_q   <= div_d;
         edge_q  <= edge_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         shift_q <= shift_d;
         data_q  <= data_d;
      end
   end

   // During DONE the freshly assembled word is shown alongside the strobe; data_q
   // captures it at the end of DONE and holds it until the next result.
   assign data_o       = (state_q == DONE) ? shift_q : data_q;
   assign data_valid_o = (state_q == DONE);
   assign busy_o       = (state_q != IDLE);
   assign delay_en_o   = (state_q == DELAY);
   assign cs_n_o       = !((state_q == SEND_CMD) || (state_q == DELAY) || (state_q == READ));
   assign sclk_o       = sclk_q;
   assign mosi_o       = mosi_q;

endmodule

// File: tb/tb_spi_adc_reader.sv
// Bench for spi_adc_reader: ADC slave model, delay-timer model and a result scoreboard
// exercised through reset, DRDY wait, ignored start, mid-read reset and back-to-back reads.
module tb_spi_adc_reader;

   localparam int CD      = 2;
   localparam int TMR_MAX = 50;
   // Start-sampling edge to the edge entering DONE: WAIT_DRDY, command, delay, read.
   localparam int LAT_EDGES = 1 + 16 * CD + (TMR_MAX + 1) + 48 * CD;
   localparam int BUDGET    = 1000;

   logic        clock_i;
   logic        reset_i;
   logic        start_i;
   logic        drdy_n_i;
   logic        delay_done;
   logic        delay_en_o;
   logic        miso = 1'b0;
   logic        sclk_o;
   logic        mosi_o;
   logic        cs_n_o;
   logic [23:0] data_o;
   logic        data_valid_o;
   logic        busy_o;

   spi_adc_reader #(.CLK_DIV(CD), .CMD_BYTE(8'h01)) dut (
      .clock_i      (clock_i),
      .reset_i      (reset_i),
      .start_i      (start_i),
      .drdy_n_i     (drdy_n_i),
      .delay_done_i (delay_done),
      .delay_en_o   (delay_en_o),
      .miso_i       (miso),
      .sclk_o       (sclk_o),
      .mosi_o       (mosi_o),
      .cs_n_o       (cs_n_o),
      .data_o       (data_o),
      .data_valid_o (data_valid_o),
      .busy_o       (busy_o)
   );

   initial clock_i = 1'b0;
   always #5 clock_i = ~clock_i;

   int n_checks = 0;
   int n_fail   = 0;
   int n_txn    = 0;
   logic [23:0] exp_q[$];
   logic [23:0] adc_word;

   // External delay timer: counts while enabled, done at TMR_MAX, clears when disabled.
   int tmr_cnt;
   always @(posedge clock_i or posedge reset_i) begin
      if (reset_i)                 tmr_cnt <= 0;
      else if (!delay_en_o)        tmr_cnt <= 0;
      else if (tmr_cnt != TMR_MAX) tmr_cnt <= tmr_cnt + 1;
   end
   assign delay_done = (tmr_cnt == TMR_MAX);

   // ADC model and bus monitor, evaluated mid-cycle.
   int         rise_cnt     = 0;
   int         cmd_rises    = 0;
   int         delay_cycles = 0;
   int         gap_bad      = 0;
   int         valid_cnt    = 0;
   logic [7:0] mosi_cap     = 8'h00;
   logic       sclk_prev    = 1'b0;
   logic       cs_prev      = 1'b1;

   always @(negedge clock_i) begin
      if (cs_prev && !cs_n_o) begin
         rise_cnt     = 0;
         cmd_rises    = 0;
         delay_cycles = 0;
         gap_bad      = 0;
         mosi_cap     = 8'h00;
      end
      if (sclk_o && !sclk_prev) begin
         rise_cnt++;
         if (rise_cnt <= 8)       mosi_cap = {mosi_cap[6:0], mosi_o};
         else if (rise_cnt <= 32) miso = adc_word[32 - rise_cnt];
      end
      if (delay_en_o) begin
         delay_cycles++;
         if (delay_cycles == 1) cmd_rises = rise_cnt;
         if (sclk_o !== 1'b0 || cs_n_o !== 1'b0) gap_bad++;
      end
      if (data_valid_o) valid_cnt++;
      sclk_prev = sclk_o;
      cs_prev   = cs_n_o;
   end

   task automatic pulse_start();
      @(posedge clock_i); #1 start_i = 1'b1;
      @(posedge clock_i); #1 start_i = 1'b0;
   endtask

   task automatic wait_valid(output int cycles, output bit ok);
      cycles = 0;
      while (!data_valid_o && cycles < BUDGET) begin
         @(posedge clock_i); #1;
         cycles++;
      end
      ok = data_valid_o;
   endtask

   task automatic wait_rises(input int n, output bit ok);
      int cycles = 0;
      while (!(cs_prev == 1'b0 && cs_n_o == 1'b0 && rise_cnt >= n) && cycles < BUDGET) begin
         @(posedge clock_i); #1;
         cycles++;
      end
      ok = (cs_n_o == 1'b0 && rise_cnt >= n);
   endtask

   task automatic test_reset();
      #2 reset_i = 1'b1;
      repeat (2) @(posedge clock_i);
      #1;
      n_checks++;
      if ({cs_n_o, sclk_o, mosi_o, delay_en_o, data_valid_o, busy_o} !== 6'b100000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 100000 (cs_n,sclk,mosi,den,valid,busy)",
                  {cs_n_o, sclk_o, mosi_o, delay_en_o, data_valid_o, busy_o});
      end
      n_checks++;
      if (data_o !== 24'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h expected 000000", data_o);
      end
      reset_i = 1'b0;
      @(posedge clock_i); #1;
      n_checks++;
      if (busy_o !== 1'b0 || cs_n_o !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release: busy=%b cs_n=%b expected busy=0 cs_n=1", busy_o, cs_n_o);
      end
   endtask

   task automatic test_basic();
      int cycles;
      bit ok;
      logic [23:0] exp;
      drdy_n_i = 1'b0;
      adc_word = 24'hA5C3F0;
      exp_q.push_back(24'hA5C3F0);
      n_txn++;
      pulse_start();
      wait_valid(cycles, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL basic_timeout: no data_valid_o within %0d cycles", BUDGET);
      end
      n_checks++;
      if (cycles != LAT_EDGES) begin
         n_fail++;
         $display("FAIL basic_latency: got %0d edges expected %0d", cycles, LAT_EDGES);
      end
      exp = exp_q.pop_front();
      n_checks++;
      if (data_o !== exp) begin
         n_fail++;
         $display("FAIL basic_data: got %h expected %h", data_o, exp);
      end
      n_checks++;
      if (mosi_cap !== 8'h01) begin
         n_fail++;
         $display("FAIL basic_mosi: got %h expected 01", mosi_cap);
      end
      n_checks++;
      if (cmd_rises != 8 || rise_cnt - cmd_rises != 24) begin
         n_fail++;
         $display("FAIL basic_sclk_count: got %0d then %0d expected 8 then 24",
                  cmd_rises, rise_cnt - cmd_rises);
      end
      n_checks++;
      if (delay_cycles < TMR_MAX || gap_bad != 0) begin
         n_fail++;
         $display("FAIL basic_gap: got %0d cycles %0d bad expected >=%0d cycles 0 bad",
                  delay_cycles, gap_bad, TMR_MAX);
      end
      @(posedge clock_i); #1;
      n_checks++;
      if (data_valid_o !== 1'b0 || busy_o !== 1'b0 || data_o !== 24'hA5C3F0) begin
         n_fail++;
         $display("FAIL basic_after: valid=%b busy=%b data=%h expected 0 0 a5c3f0",
                  data_valid_o, busy_o, data_o);
      end
   endtask

   task automatic test_drdy_wait();
      int cycles;
      int bad = 0;
      bit ok;
      logic [23:0] exp;
      drdy_n_i = 1'b1;
      adc_word = 24'h3C5A96;
      exp_q.push_back(24'h3C5A96);
      n_txn++;
      pulse_start();
      repeat (100) begin
         @(posedge clock_i); #1;
         if (cs_n_o !== 1'b1 || sclk_o !== 1'b0 || busy_o !== 1'b1) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL drdy_hold: got %0d bad cycles expected 0", bad);
      end
      drdy_n_i = 1'b0;
      @(posedge clock_i); #1;
      n_checks++;
      if (cs_n_o !== 1'b0) begin
         n_fail++;
         $display("FAIL drdy_cs: got cs_n=%b expected 0", cs_n_o);
      end
      wait_valid(cycles, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL drdy_timeout: no data_valid_o within %0d cycles", BUDGET);
      end
      exp = exp_q.pop_front();
      n_checks++;
      if (data_o !== exp) begin
         n_fail++;
         $display("FAIL drdy_data: got %h expected %h", data_o, exp);
      end
   endtask

   task automatic test_start_ignored();
      int cycles;
      int bad = 0;
      int vcnt;
      bit ok;
      logic [23:0] exp;
      adc_word = 24'h5A0F3C;
      exp_q.push_back(24'h5A0F3C);
      n_txn++;
      pulse_start();
      wait_rises(20, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL ignore_reach_read: rises=%0d expected >=20", rise_cnt);
      end
      pulse_start();
      wait_valid(cycles, ok);
      exp = exp_q.pop_front();
      n_checks++;
      if (!ok || data_o !== exp) begin
         n_fail++;
         $display("FAIL ignore_data: got valid=%b data=%h expected 1 %h", ok, data_o, exp);
      end
      @(posedge clock_i); #1;
      n_checks++;
      if (busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL ignore_busy: got %b expected 0", busy_o);
      end
      vcnt = valid_cnt;
      repeat (200) begin
         @(posedge clock_i); #1;
         if (busy_o !== 1'b0 || cs_n_o !== 1'b1) bad++;
      end
      n_checks++;
      if (bad != 0 || valid_cnt != vcnt) begin
         n_fail++;
         $display("FAIL ignore_no_second: got %0d busy cycles %0d extra valids expected 0 0",
                  bad, valid_cnt - vcnt);
      end
      n_checks++;
      if (data_o !== 24'h5A0F3C) begin
         n_fail++;
         $display("FAIL ignore_hold: got %h expected 5a0f3c", data_o);
      end
   endtask

   task automatic test_reset_abort();
      int cycles;
      int vcnt;
      bit ok;
      logic [23:0] exp;
      adc_word = 24'hDEAD00;
      pulse_start();
      wait_rises(18, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL abort_reach_read: rises=%0d expected >=18", rise_cnt);
      end
      vcnt = valid_cnt;
      #2 reset_i = 1'b1;
      #1;
      n_checks++;
      if ({cs_n_o, sclk_o, delay_en_o, busy_o} !== 4'b1000 || data_o !== 24'h0) begin
         n_fail++;
         $display("FAIL abort_async: got cs_n,sclk,den,busy=%b data=%h expected 1000 000000",
                  {cs_n_o, sclk_o, delay_en_o, busy_o}, data_o);
      end
      repeat (3) @(posedge clock_i);
      #1 reset_i = 1'b0;
      repeat (5) @(posedge clock_i);
      #1;
      n_checks++;
      if (valid_cnt != vcnt) begin
         n_fail++;
         $display("FAIL abort_no_valid: got %0d valid pulses expected 0", valid_cnt - vcnt);
      end
      adc_word = 24'h123456;
      exp_q.push_back(24'h123456);
      n_txn++;
      pulse_start();
      wait_valid(cycles, ok);
      exp = exp_q.pop_front();
      n_checks++;
      if (!ok || data_o !== exp || cycles != LAT_EDGES) begin
         n_fail++;
         $display("FAIL abort_recover: got valid=%b data=%h edges=%0d expected 1 %h %0d",
                  ok, data_o, cycles, exp, LAT_EDGES);
      end
   endtask

   task automatic test_back_to_back();
      int cycles;
      bit ok;
      logic [23:0] exp;
      adc_word = 24'hFFFFFF;
      exp_q.push_back(24'hFFFFFF);
      n_txn++;
      pulse_start();
      wait_valid(cycles, ok);
      exp = exp_q.pop_front();
      n_checks++;
      if (!ok || data_o !== exp) begin
         n_fail++;
         $display("FAIL b2b_first: got valid=%b data=%h expected 1 %h", ok, data_o, exp);
      end
      n_checks++;
      if (delay_en_o !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_den_drop: got delay_en=%b expected 0", delay_en_o);
      end
      adc_word = 24'h000000;
      exp_q.push_back(24'h000000);
      n_txn++;
      pulse_start();
      wait_valid(cycles, ok);
      exp = exp_q.pop_front();
      n_checks++;
      if (!ok || data_o !== exp) begin
         n_fail++;
         $display("FAIL b2b_second: got valid=%b data=%h expected 1 %h", ok, data_o, exp);
      end
      n_checks++;
      if (delay_cycles < TMR_MAX) begin
         n_fail++;
         $display("FAIL b2b_rearm: got %0d delay cycles expected >=%0d", delay_cycles, TMR_MAX);
      end
   endtask

   task automatic test_scoreboard_drained();
      repeat (2) @(posedge clock_i);
      #1;
      n_checks++;
      if (exp_q.size() != 0 || valid_cnt != n_txn) begin
         n_fail++;
         $display("FAIL sb_drained: got %0d pending %0d valids expected 0 pending %0d valids",
                  exp_q.size(), valid_cnt, n_txn);
      end
   endtask

   initial begin
      reset_i  = 1'b0;
      start_i  = 1'b0;
      drdy_n_i = 1'b1;
      adc_word = 24'h0;
      test_reset();
      test_basic();
      test_drdy_wait();
      test_start_ignored();
      test_reset_abort();
      test_back_to_back();
      test_scoreboard_drained();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
